// File: rtl/score_digit_renderer.sv
// BCD score accumulator that adds one digit per cycle and saturates at all 9s, plus a seven-segment pixel renderer.
// Optional LEADING_ZERO_BLANK_EN: digits above the most significant nonzero displayed digit are drawn as background.
module score_digit_renderer #(
    parameter int          NUM_DIGITS  = 4,
    parameter int          ORIGIN_X    = 50,
    parameter int          ORIGIN_Y    = 139,
    parameter int          DIGIT_W     = 20,
    parameter int          DIGIT_PITCH = 25,
    parameter int          SEG_H       = 7,
    parameter int          SEG_V_W     = 5,
    parameter logic [11:0] FG          = 12'hFFF,
    parameter logic [11:0] BG          = 12'h844
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    input  logic                    frame_start,
    input  logic                    add_valid,
    input  logic [2:0]              lines_cleared,
    output logic                    add_ready,
    input  logic                    score_clear,
    output logic [4*NUM_DIGITS-1:0] score_bcd,
    output logic                    overflow,
    output logic                    in_region,
    output logic [11:0]             colour
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SW = 4 * NUM_DIGITS;

    typedef enum logic {S_IDLE, S_ADD} state_t;

    state_t          r_state;
    logic            r_add_ready;
    logic [SW-1:0]   r_score;
    logic [SW-1:0]   r_shadow;
    logic            r_overflow;
    logic [IW-1:0]   r_idx;
    logic [3:0]      r_points;
    logic            r_carry;
    logic            r_in_region;
    logic [11:0]     r_colour;

    function automatic logic [3:0] points_of(input logic [2:0] lc);
        case (lc)
            3'd1:    points_of = 4'd1;
            3'd2:    points_of = 4'd3;
            3'd3:    points_of = 4'd5;
            3'd4:    points_of = 4'd8;
            default: points_of = 4'd0;
        endcase
    endfunction

    // Segment bits are {g,f,e,d,c,b,a}; codes 10..15 decode to blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    logic [3:0] w_cur;
    logic [3:0] w_add;
    logic [4:0] w_sum;
    logic       w_cout;
    logic [3:0] w_new;
    logic       w_last;

    assign w_cur  = r_score[{r_idx, 2'b00} +: 4];
    assign w_add  = (r_idx == '0) ? r_points : 4'd0;
    assign w_sum  = {1'b0, w_cur} + {1'b0, w_add} + {4'd0, r_carry};
    assign w_cout = (w_sum > 5'd9);
    // Adding 6 modulo 16 is the same as subtracting 10 for sums 10..18.
    assign w_new  = w_sum[3:0] + (w_cout ? 4'd6 : 4'd0);
    assign w_last = (r_idx == IW'(NUM_DIGITS - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_add_ready <= 1'b0;
            r_score     <= '0;
            r_overflow  <= 1'b0;
            r_idx       <= '0;
            r_points    <= 4'd0;
            r_carry     <= 1'b0;
        end else if (score_clear) begin
            r_state     <= S_IDLE;
            r_add_ready <= 1'b1;
            r_score     <= '0;
            r_overflow  <= 1'b0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_add_ready <= 1'b1;
                    if (add_valid && r_add_ready) begin
                        r_points    <= points_of(lines_cleared);
                        r_idx       <= '0;
                        r_carry     <= 1'b0;
                        r_add_ready <= 1'b0;
                        r_state     <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_score[{r_idx, 2'b00} +: 4] <= w_new;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + IW'(1);
                    if (w_last) begin
                        r_state     <= S_IDLE;
                        r_add_ready <= 1'b1;
                        if (w_cout) begin
                            r_score    <= {NUM_DIGITS{4'h9}};
                            r_overflow <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The shadow only follows a settled score so a frame never shows a half-added value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_shadow <= '0;
        end else if (frame_start && (r_state == S_IDLE)) begin
            r_shadow <= r_score;
        end
    end

    int                    w_xi;
    int                    w_ry;
    logic                  w_rows;
    logic [4:0]            w_band;
    logic [NUM_DIGITS-1:0] w_box;
    logic [NUM_DIGITS-1:0] w_lit;
    logic [NUM_DIGITS-1:0] w_show;

    assign w_xi   = {22'd0, x};
    assign w_ry   = {22'd0, y} - ORIGIN_Y;
    assign w_rows = (w_ry >= 0) && (w_ry < 5 * SEG_H);

    for (genvar b = 0; b < 5; b++) begin : g_band
        assign w_band[b] = (w_ry >= b * SEG_H) && (w_ry < (b + 1) * SEG_H);
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        localparam int L = ORIGIN_X + (NUM_DIGITS - 1 - k) * DIGIT_PITCH;
        int         w_rx;
        logic [6:0] w_seg;
        logic       w_left;
        logic       w_right;

        assign w_rx     = w_xi - L;
        assign w_seg    = seg_decode(r_shadow[4*k +: 4]);
        assign w_left   = (w_rx < SEG_V_W);
        assign w_right  = (w_rx >= DIGIT_W - SEG_V_W);
        assign w_box[k] = w_rows && (w_rx >= 0) && (w_rx < DIGIT_W);
        assign w_lit[k] = (w_band[0] & w_seg[0])
                        | (w_band[1] & ((w_left & w_seg[5]) | (w_right & w_seg[1])))
                        | (w_band[2] & w_seg[6])
                        | (w_band[3] & ((w_left & w_seg[4]) | (w_right & w_seg[2])))
                        | (w_band[4] & w_seg[3]);
`ifdef LEADING_ZERO_BLANK_EN
        if (k == 0) begin : g_units
            assign w_show[k] = 1'b1;
        end else begin : g_upper
            assign w_show[k] = |r_shadow[SW-1:4*k];
        end
`else
        assign w_show[k] = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_in_region <= 1'b0;
            r_colour    <= 12'h000;
        end else begin
            r_in_region <= |w_box;
            r_colour    <= (|(w_box & w_lit & w_show)) ? FG : BG;
        end
    end

    assign add_ready = r_add_ready;
    assign score_bcd = r_score;
    assign overflow  = r_overflow;
    assign in_region = r_in_region;
    assign colour    = r_colour;

endmodule

// File: tb/tb_score_digit_renderer.sv
// Directed bench for score_digit_renderer: accumulation, saturation, clear priority, shadowing and pixel geometry.
module tb_score_digit_renderer;

    localparam logic [11:0] FG = 12'hFFF;
    localparam logic [11:0] BG = 12'h844;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [11:0] LZ = BG;
`else
    localparam logic [11:0] LZ = FG;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        frame_start;
    logic        add_valid;
    logic [2:0]  lines_cleared;
    logic        add_ready;
    logic        score_clear;
    logic [15:0] score_bcd;
    logic        overflow;
    logic        in_region;
    logic [11:0] colour;

    int n_tests = 0;
    int n_fail  = 0;

    score_digit_renderer dut (
        .clk           (clk),
        .resetn        (resetn),
        .x             (x),
        .y             (y),
        .frame_start   (frame_start),
        .add_valid     (add_valid),
        .lines_cleared (lines_cleared),
        .add_ready     (add_ready),
        .score_clear   (score_clear),
        .score_bcd     (score_bcd),
        .overflow      (overflow),
        .in_region     (in_region),
        .colour        (colour)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input string tag, input int px, input int py,
                       input logic exp_in, input logic [11:0] exp_col);
        x = 10'(px);
        y = 10'(py);
        tick();
        check({tag, "_in"},  32'(in_region), 32'(exp_in));
        check({tag, "_col"}, 32'(colour),    32'(exp_col));
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && add_ready !== 1'b1; i++) tick();
        if (add_ready !== 1'b1) check("ready_timeout", 32'(add_ready), 32'd1);
    endtask

    task automatic do_event(input logic [2:0] lc);
        wait_ready();
        add_valid     = 1'b1;
        lines_cleared = lc;
        tick();
        add_valid = 1'b0;
        wait_ready();
    endtask

    task automatic clear_score();
        score_clear = 1'b1;
        tick();
        score_clear = 1'b0;
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        resetn        = 1'b0;
        x             = 10'd300;
        y             = 10'd150;
        frame_start   = 1'b0;
        add_valid     = 1'b0;
        lines_cleared = 3'd0;
        score_clear   = 1'b0;

        tick();
        tick();
        check("rst_ready",  32'(add_ready), 32'd0);
        check("rst_score",  32'(score_bcd), 32'h0000);
        check("rst_ovf",    32'(overflow),  32'd0);
        check("rst_inreg",  32'(in_region), 32'd0);
        check("rst_colour", 32'(colour),    32'h000);

        resetn = 1'b1;
        x      = 10'd0;
        y      = 10'd0;
        tick();
        check("rel_ready",  32'(add_ready), 32'd1);
        check("rel_inreg",  32'(in_region), 32'd0);
        check("rel_colour", 32'(colour),    32'(BG));

        // Four lines on a zero score: four busy cycles then 0008
        add_valid     = 1'b1;
        lines_cleared = 3'd4;
        tick();
        check("xfer_ready", 32'(add_ready), 32'd0);
        add_valid = 1'b0;
        repeat (3) begin
            tick();
            check("add_busy", 32'(add_ready), 32'd0);
        end
        tick();
        check("add_done_ready", 32'(add_ready), 32'd1);
        check("score_0008",     32'(score_bcd), 32'h0008);
        check("ovf_0008",       32'(overflow),  32'd0);
        pix("pre_frame_g", 130, 156, 1'b1, BG);
        frame_pulse();
        pix("post_frame_g", 130, 156, 1'b1, FG);
        pix("units_f",      125, 146, 1'b1, FG);
        pix("units_b",      140, 146, 1'b1, FG);

        // Carry ripple 0998 + 5
        clear_score();
        check("clr_score", 32'(score_bcd), 32'h0000);
        repeat (124) do_event(3'd4);
        do_event(3'd3);
        do_event(3'd1);
        check("score_0998", 32'(score_bcd), 32'h0998);
        do_event(3'd3);
        check("score_1003", 32'(score_bcd), 32'h1003);
        check("ovf_1003",   32'(overflow),  32'd0);
        do_event(3'd7);
        check("zero_points", 32'(score_bcd), 32'h1003);

        // Saturation and sticky overflow
        repeat (1123) do_event(3'd4);
        do_event(3'd3);
        do_event(3'd3);
        check("score_9997", 32'(score_bcd), 32'h9997);
        check("ovf_9997",   32'(overflow),  32'd0);
        do_event(3'd4);
        check("sat_score", 32'(score_bcd), 32'h9999);
        check("sat_ovf",   32'(overflow),  32'd1);
        do_event(3'd1);
        check("sticky_score", 32'(score_bcd), 32'h9999);
        check("sticky_ovf",   32'(overflow),  32'd1);
        clear_score();
        check("clr2_score", 32'(score_bcd), 32'h0000);
        check("clr2_ovf",   32'(overflow),  32'd0);
        check("clr2_ready", 32'(add_ready), 32'd1);

        // Clear aborts an add; held valid yields exactly one new transfer
        do_event(3'd1);
        check("score_0001", 32'(score_bcd), 32'h0001);
        add_valid     = 1'b1;
        lines_cleared = 3'd2;
        tick();
        check("abort_xfer", 32'(add_ready), 32'd0);
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        score_clear = 1'b1;
        tick();
        score_clear = 1'b0;
        check("abort_score", 32'(score_bcd), 32'h0000);
        check("abort_ready", 32'(add_ready), 32'd1);
        tick();
        check("retry_xfer", 32'(add_ready), 32'd0);
        add_valid = 1'b0;
        wait_ready();
        check("retry_score", 32'(score_bcd), 32'h0003);
        pix("shadow_hold_a", 130, 140, 1'b1, FG);
        pix("shadow_hold_d", 130, 170, 1'b1, FG);

        // Shadow 0007 rendering and box boundaries
        clear_score();
        do_event(3'd3);
        do_event(3'd1);
        do_event(3'd1);
        check("score_0007", 32'(score_bcd), 32'h0007);
        frame_pulse();
        pix("thou_a",      50,  139, 1'b1, LZ);
        pix("hund_a",      75,  139, 1'b1, LZ);
        pix("tens_a",      100, 139, 1'b1, LZ);
        pix("units7_a",    130, 139, 1'b1, FG);
        pix("units7_g",    130, 156, 1'b1, BG);
        pix("units7_f",    125, 146, 1'b1, BG);
        pix("units7_bedge",144, 146, 1'b1, FG);
        pix("right_out",   145, 146, 1'b0, BG);
        pix("last_row_d",  130, 173, 1'b1, BG);
        pix("below_box",   130, 174, 1'b0, BG);
        pix("digit_gap",   72,  150, 1'b0, BG);
        pix("above_box",   130, 138, 1'b0, BG);

        // Asynchronous reset in the middle of an add while drawing
        x             = 10'd130;
        y             = 10'd139;
        add_valid     = 1'b1;
        lines_cleared = 3'd4;
        tick();
        add_valid = 1'b0;
        tick();
        check("pre_rst_inreg", 32'(in_region), 32'd1);
        resetn = 1'b0;
        #2;
        check("arst_score",  32'(score_bcd), 32'h0000);
        check("arst_ready",  32'(add_ready), 32'd0);
        check("arst_ovf",    32'(overflow),  32'd0);
        check("arst_inreg",  32'(in_region), 32'd0);
        check("arst_colour", 32'(colour),    32'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
